fpu_rr_scheduler: RTL

// Shares one multi-cycle fpu_16bit core among NUM_REQ requesters. Round-robin arbitration, one op in flight.

---
 rtl/fpu_rr_scheduler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fpu_rr_scheduler.sv
// fpu_rr_scheduler: shares one multi-cycle fpu_16bit core among NUM_REQ requesters.
// Round-robin grant, a single op in flight, tagged response channel with valid/ready.
// Optional macro FPU_ARB_TIMEOUT_EN adds a WAIT-state watchdog that aborts with resp_err=1.
module fpu_rr_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*16-1:0] req_x,
    input  logic [NUM_REQ*16-1:0] req_y,
    input  logic [NUM_REQ*2-1:0]  req_op,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [15:0]           resp_result,
    output logic [1:0]            resp_ofuf,
    output logic [2:0]            resp_cmp,
    output logic                  resp_err,
    output logic                  busy,
    output logic [15:0]           fpu_x,
    output logic [15:0]           fpu_y,
    output logic [1:0]            fpu_op,
    output logic                  fpu_rst,
    input  logic                  fpu_done,
    input  logic [15:0]           fpu_result,
    input  logic [1:0]            fpu_ofuf,
    input  logic [2:0]            fpu_cmp
);

    localparam int unsigned N_U = NUM_REQ;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_SETTLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_ptr;
    logic [15:0]       r_fpu_x;
    logic [15:0]       r_fpu_y;
    logic [1:0]        r_fpu_op;
    logic [ID_W-1:0]   r_resp_id;
    logic [15:0]       r_resp_result;
    logic [1:0]        r_resp_ofuf;
    logic [2:0]        r_resp_cmp;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_gnt_id;
    logic               w_gnt_any;
    logic [ID_W-1:0]    w_cand;

    // Parameter sanity: at least two requesters, id wide enough, non-zero watchdog budget.
    if (NUM_REQ < 2 || (1 << ID_W) < NUM_REQ || TIMEOUT_CYC < 1) begin : g_bad_params
        // Intentionally empty: unsupported configuration, left for lint/elaboration review.
    end

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_resp_err;
    assign resp_err = r_resp_err;
`else
    assign resp_err = 1'b0;
`endif

    // Round-robin pick: first valid requester strictly after the last one served, wrapping.
    always_comb begin
        w_grant   = '0;
        w_gnt_id  = '0;
        w_gnt_any = 1'b0;
        w_cand    = '0;
        for (int unsigned k = 1; k <= N_U; k++) begin
            w_cand = ID_W'((32'(r_ptr) + k) % N_U);
            if (!w_gnt_any && req_valid[w_cand]) begin
                w_grant[w_cand] = 1'b1;
                w_gnt_id        = w_cand;
                w_gnt_any       = 1'b1;
            end
        end
    end

    assign req_ready   = (r_state == S_IDLE && !reset) ? w_grant : '0;
    assign resp_valid  = (r_state == S_RESP);
    assign busy        = (r_state != S_IDLE);
    assign fpu_rst     = reset | (r_state == S_LAUNCH);
    assign fpu_x       = r_fpu_x;
    assign fpu_y       = r_fpu_y;
    assign fpu_op      = r_fpu_op;
    assign resp_id     = r_resp_id;
    assign resp_result = r_resp_result;
    assign resp_ofuf   = r_resp_ofuf;
    assign resp_cmp    = r_resp_cmp;

    // Scheduler FSM: grant, launch, settle, wait for the FPU, hold the response until popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_ptr         <= ID_W'(NUM_REQ - 1);
            r_fpu_x       <= '0;
            r_fpu_y       <= '0;
            r_fpu_op      <= '0;
            r_resp_id     <= '0;
            r_resp_result <= '0;
            r_resp_ofuf   <= '0;
            r_resp_cmp    <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
            r_cnt         <= '0;
            r_resp_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A grant is a handshake: req_ready mirrors w_grant in IDLE.
                    if (w_gnt_any) begin
                        r_fpu_x  <= req_x[16*w_gnt_id +: 16];
                        r_fpu_y  <= req_y[16*w_gnt_id +: 16];
                        r_fpu_op <= req_op[2*w_gnt_id +: 2];
                        r_ptr    <= w_gnt_id;
                        r_state  <= S_LAUNCH;
                    end
                end
                S_LAUNCH: r_state <= S_SETTLE;
                S_SETTLE: begin
                    // fpu_done may still be high from the previous op here; it is ignored.
`ifdef FPU_ARB_TIMEOUT_EN
                    r_cnt <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (fpu_done) begin
                        // r_ptr only moves on a handshake, so it still names the issuing requester.
                        r_resp_id     <= r_ptr;
                        r_resp_result <= fpu_result;
                        r_resp_ofuf   <= fpu_ofuf;
                        r_resp_cmp    <= fpu_cmp;
`ifdef FPU_ARB_TIMEOUT_EN
                        r_resp_err    <= 1'b0;
`endif
                        r_state       <= S_RESP;
                    end
`ifdef FPU_ARB_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        r_resp_id     <= r_ptr;
                        r_resp_result <= '0;
                        r_resp_ofuf   <= '0;
                        r_resp_cmp    <= '0;
                        r_resp_err    <= 1'b1;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
